// File: rtl/gate_boy_pkg.sv
// gate_boy_pkg: shared widths, ALU opcode encoding, flag bit positions and
// FSM state types for the SM83 ALU path.
package gate_boy_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int OPCODE_WIDTH = 4;
  localparam int FLAG_WIDTH   = 4;

  // flags_out = {Z,N,H,C}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_XOR = 4'd5,
    ALU_OR  = 4'd6,
    ALU_CP  = 4'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } sbc_state_t;

  // Opcodes the subtract unit produces a result for.
  function automatic logic is_sub_op(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP);
  endfunction

endpackage

// File: rtl/sbc_nibble_sub.sv
// nibble_sub: combinational 4-bit subtractor, diff = a - b - bin.
//   a, b  : nibble operands
//   bin   : borrow in
//   diff  : 4-bit difference (mod 16)
//   bout  : borrow out of bit 3
module nibble_sub (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  // Extending to 5 bits makes the MSB the borrow: it is set exactly when
  // a - b - bin goes negative.
  assign {bout, diff} = {1'b0, a} - {1'b0, b} - {4'b0, bin};

endmodule

// File: rtl/sbc.sv
// sbc: nibble-serial SUB/SBC/CP unit. Operands launch on a phi rising edge
// (seen in the clk domain); low nibble is computed, then high nibble through
// one shared 4-bit subtractor; result and flags register 3 clk after launch.
//   clk, rst     : 4 MHz clock, synchronous active-high reset
//   phi          : M-cycle phase (2 clk high, 2 clk low)
//   op_valid     : qualifies operands/opcode at a phi rise
//   operand_A/B  : minuend / subtrahend
//   carry_in     : C flag, used by SBC only
//   opcode       : alu_op_t encoding
//   result       : registered 8-bit result (A for CP)
//   flags_out    : registered {Z,N,H,C}
//   result_valid : one-clk pulse when result/flags_out update
//   busy         : high while an operation is in flight
module sbc
  import gate_boy_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    phi,
  input  logic                    op_valid,
  input  logic [DATA_WIDTH-1:0]   operand_A,
  input  logic [DATA_WIDTH-1:0]   operand_B,
  input  logic                    carry_in,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0]   result,
  output logic [FLAG_WIDTH-1:0]   flags_out,
  output logic                    result_valid,
  output logic                    busy
);

  sbc_state_t            state;
  logic                  phi_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  cin_q;
  alu_op_t               op_q;
  logic [3:0]            lo_q, hi_q;
  logic                  hb_q, c_q;

  logic                  launch;
  logic [3:0]            ns_a, ns_b, ns_diff;
  logic                  ns_bin, ns_bout;

  // phi_q resets high so a phi already high at reset release is not a rise.
  assign launch = phi & ~phi_q & op_valid & (state == IDLE);
  assign busy   = (state != IDLE);

  // Shared subtractor: low nibble with cin in LO, high nibble with the
  // stored half-borrow otherwise (only meaningful in HI).
  always_comb begin
    ns_a   = a_q[3:0];
    ns_b   = b_q[3:0];
    ns_bin = cin_q;
    if (state == HI) begin
      ns_a   = a_q[7:4];
      ns_b   = b_q[7:4];
      ns_bin = hb_q;
    end
  end

  nibble_sub u_nibble_sub (
    .a    (ns_a),
    .b    (ns_b),
    .bin  (ns_bin),
    .diff (ns_diff),
    .bout (ns_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      phi_q        <= 1'b1;
      result       <= '0;
      flags_out    <= '0;
      result_valid <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      op_q         <= ALU_ADD;
      lo_q         <= '0;
      hi_q         <= '0;
      hb_q         <= 1'b0;
      c_q          <= 1'b0;
    end else begin
      phi_q        <= phi;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            a_q   <= operand_A;
            b_q   <= operand_B;
            cin_q <= (opcode == ALU_SBC) ? carry_in : 1'b0;
            op_q  <= alu_op_t'(opcode);
            state <= LO;
          end
        end
        LO: begin
          lo_q  <= ns_diff;
          hb_q  <= ns_bout;
          state <= HI;
        end
        HI: begin
          hi_q  <= ns_diff;
          c_q   <= ns_bout;
          state <= DONE;
        end
        DONE: begin
          // Unsupported opcodes fall through silently, outputs untouched.
          if (is_sub_op(op_q)) begin
            result            <= (op_q == ALU_CP) ? a_q : {hi_q, lo_q};
            flags_out[FLAG_Z] <= ({hi_q, lo_q} == 8'h00);
            flags_out[FLAG_N] <= 1'b1;
            flags_out[FLAG_H] <= hb_q;
            flags_out[FLAG_C] <= c_q;
            result_valid      <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sbc.sv
// tb_sbc: directed vectors for sbc; expected responses are queued at issue
// time and checked by an independent monitor on each result_valid pulse.
module tb_sbc;
  import gate_boy_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    phi;
  logic                    op_valid;
  logic [DATA_WIDTH-1:0]   a, b;
  logic                    carry_in;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [DATA_WIDTH-1:0]   result;
  logic [FLAG_WIDTH-1:0]   flags_out;
  logic                    result_valid;
  logic                    busy;

  sbc dut (
    .clk          (clk),
    .rst          (rst),
    .phi          (phi),
    .op_valid     (op_valid),
    .operand_A    (a),
    .operand_B    (b),
    .carry_in     (carry_in),
    .opcode       (opcode),
    .result       (result),
    .flags_out    (flags_out),
    .result_valid (result_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // phi: high for ph 0,1 and low for ph 2,3; ph advances on negedge.
  logic [1:0] ph = 2'd3;
  always @(negedge clk) ph <= ph + 2'd1;
  assign phi = ~ph[1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r;
    logic [3:0] f;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Monitor: every result_valid pulse must match the oldest expectation,
  // including the cycle it was due.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", {31'b0, result_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result",  {24'b0, result},    {24'b0, e.r});
        chk("flags",   {28'b0, flags_out}, {28'b0, e.f});
        chk("latency", cyc,                e.cyc);
      end
    end
  end

  task automatic wait_rise();
    do begin
      @(negedge clk); #1;
    end while (ph != 2'd0);
  endtask

  // Present an op on the next phi rise; launch posedge follows, and the
  // valid pulse is visible 3 posedges after that (cyc + 4 from here).
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       input alu_op_t iop, input bit exp_v,
                       input logic [7:0] er, input logic [3:0] ef);
    wait_rise();
    a        = ia;
    b        = ib;
    carry_in = ic;
    opcode   = iop;
    op_valid = 1'b1;
    if (exp_v) sb.push_back('{er, ef, cyc + 4});
    @(negedge clk); #1;
    op_valid = 1'b0;
  endtask

  initial begin
    int t;
    rst      = 1'b1;
    op_valid = 1'b0;
    a        = '0;
    b        = '0;
    carry_in = 1'b0;
    opcode   = ALU_SUB;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_result", {24'b0, result},       32'h0);
    chk("rst_flags",  {28'b0, flags_out},    32'h0);
    chk("rst_valid",  {31'b0, result_valid}, 32'h0);
    chk("rst_busy",   {31'b0, busy},         32'h0);

    // Release reset with phi already high and op_valid asserted: no launch.
    a = 8'h55; b = 8'h11; opcode = ALU_SUB; op_valid = 1'b1;
    do begin
      @(negedge clk); #1;
    end while (ph != 2'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("no_launch_at_release", {31'b0, busy}, 32'h0);
    op_valid = 1'b0;

    issue(8'h3E, 8'h3E, 1'b0, ALU_SUB, 1, 8'h00, 4'b1100);
    issue(8'h3E, 8'h0F, 1'b1, ALU_SUB, 1, 8'h2F, 4'b0110);
    issue(8'h3B, 8'h2A, 1'b1, ALU_SBC, 1, 8'h10, 4'b0100);
    issue(8'h00, 8'hFF, 1'b1, ALU_SBC, 1, 8'h00, 4'b1111);
    issue(8'h3C, 8'h40, 1'b0, ALU_CP,  1, 8'h3C, 4'b0101);
    issue(8'h12, 8'h34, 1'b0, ALU_SUB, 1, 8'hDE, 4'b0111);
    issue(8'hFF, 8'h01, 1'b1, ALU_ADD, 0, 8'h00, 4'b0000);
    repeat (6) @(negedge clk);
    #1;
    chk("unsup_result", {24'b0, result},    32'hDE);
    chk("unsup_flags",  {28'b0, flags_out}, 32'h7);
    chk("unsup_busy",   {31'b0, busy},      32'h0);

    // Reset at T+1 of a SUB while phi is still high.
    wait_rise();
    a = 8'h80; b = 8'h01; carry_in = 1'b0; opcode = ALU_SUB; op_valid = 1'b1;
    @(negedge clk); #1;
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("midrst_result", {24'b0, result},    32'h0);
    chk("midrst_flags",  {28'b0, flags_out}, 32'h0);
    chk("midrst_busy",   {31'b0, busy},      32'h0);
    // phi is low here; op_valid held must not launch before the next rise.
    op_valid = 1'b1;
    @(negedge clk); #1;
    chk("no_launch_phi_low", {31'b0, busy}, 32'h0);
    op_valid = 1'b0;
    issue(8'h80, 8'h01, 1'b0, ALU_SUB, 1, 8'h7F, 4'b0110);

    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk("drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
